// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-requester add/sub arbiter.
package alu_arb_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between two requesters, one consumer and the shared add/sub arbiter.
interface alu_share_arbiter_if #(
  parameter int unsigned WIDTH = alu_arb_pkg::DEFAULT_WIDTH
) ();

  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req0_sub;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             req1_sub;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_s;
  logic             rsp_cout;

  logic             busy;

  // Requesters and the result consumer.
  modport master (
    output req0_valid, req0_a, req0_b, req0_sub,
    output req1_valid, req1_a, req1_b, req1_sub,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_s, rsp_cout, busy
  );

  // The arbiter itself.
  modport slave (
    input  req0_valid, req0_a, req0_b, req0_sub,
    input  req1_valid, req1_a, req1_b, req1_sub,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_s, rsp_cout, busy
  );

endinterface

// File: rtl/addsub_core.sv
// Combinational WIDTH-bit adder/subtractor: S = A + (B ^ {sub}) + sub, with carry out.
module addsub_core
  import alu_arb_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             sub_i,
  output logic [WIDTH-1:0] s_o,
  output logic             cout_o
);

  logic             cin;
  logic [WIDTH-1:0] b_x;
  logic [WIDTH:0]   full;

  always_comb begin
    cin    = (sub_i == OP_SUB);
    b_x    = b_i ^ {WIDTH{cin}};
    full   = {1'b0, a_i} + {1'b0, b_x} + {{WIDTH{1'b0}}, cin};
    s_o    = full[WIDTH-1:0];
    // For subtraction a set carry means no borrow (A >= B).
    cout_o = full[WIDTH];
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one add/sub core between two requesters (IDLE -> EXEC -> RESP).
// Defining ALU_ARB_STATS_EN adds saturating per-requester grant counters grant_cnt0/grant_cnt1.
module alu_share_arbiter
  import alu_arb_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  alu_share_arbiter_if.slave   bus
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [7:0]           grant_cnt0,
  output logic [7:0]           grant_cnt1
`endif
);

  state_e           state_q, state_d;
  logic             last_grant_q;
  logic             grant_id;
  logic             grant_vld;

  logic [WIDTH-1:0] a_q, b_q;
  logic             sub_q;
  logic             id_q;

  logic [WIDTH-1:0] rsp_s_q;
  logic             rsp_cout_q;
  logic             rsp_id_q;

  logic [WIDTH-1:0] core_s;
  logic             core_cout;

  // Grant decision; reset gates it so no ready can be seen while reset is high.
  always_comb begin
    grant_id  = 1'b0;
    grant_vld = 1'b0;
    if (state_q == IDLE && !reset) begin
      case ({bus.req1_valid, bus.req0_valid})
        2'b01: begin
          grant_id  = 1'b0;
          grant_vld = 1'b1;
        end
        2'b10: begin
          grant_id  = 1'b1;
          grant_vld = 1'b1;
        end
        2'b11: begin
          grant_id  = ~last_grant_q;
          grant_vld = 1'b1;
        end
        default: begin
          grant_id  = 1'b0;
          grant_vld = 1'b0;
        end
      endcase
    end
  end

  // A grant is only issued to a valid requester, so a grant is a handshake.
  always_comb begin
    bus.req0_ready = grant_vld && !grant_id;
    bus.req1_ready = grant_vld && grant_id;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (grant_vld) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      a_q          <= '0;
      b_q          <= '0;
      sub_q        <= OP_ADD;
      id_q         <= 1'b0;
      rsp_s_q      <= '0;
      rsp_cout_q   <= 1'b0;
      rsp_id_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant_vld) begin
        a_q          <= grant_id ? bus.req1_a   : bus.req0_a;
        b_q          <= grant_id ? bus.req1_b   : bus.req0_b;
        sub_q        <= grant_id ? bus.req1_sub : bus.req0_sub;
        id_q         <= grant_id;
        last_grant_q <= grant_id;
      end
      if (state_q == EXEC) begin
        rsp_s_q    <= core_s;
        rsp_cout_q <= core_cout;
        rsp_id_q   <= id_q;
      end
    end
  end

  addsub_core #(
    .WIDTH (WIDTH)
  ) u_addsub_core (
    .a_i    (a_q),
    .b_i    (b_q),
    .sub_i  (sub_q),
    .s_o    (core_s),
    .cout_o (core_cout)
  );

  always_comb begin
    bus.rsp_valid = (state_q == RESP);
    bus.rsp_s     = rsp_s_q;
    bus.rsp_cout  = rsp_cout_q;
    bus.rsp_id    = rsp_id_q;
    bus.busy      = (state_q != IDLE);
  end

`ifdef ALU_ARB_STATS_EN
  logic [7:0] grant_cnt0_q, grant_cnt1_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      grant_cnt0_q <= 8'd0;
      grant_cnt1_q <= 8'd0;
    end else if (grant_vld) begin
      if (!grant_id && grant_cnt0_q != 8'hff) grant_cnt0_q <= grant_cnt0_q + 8'd1;
      if (grant_id && grant_cnt1_q != 8'hff)  grant_cnt1_q <= grant_cnt1_q + 8'd1;
    end
  end

  always_comb begin
    grant_cnt0 = grant_cnt0_q;
    grant_cnt1 = grant_cnt1_q;
  end
`endif

endmodule

// File: doc/alu_share_arbiter.md
ALU_SHARE_ARBITER -- requirements
Module: alu_share_arbiter

Interface
REQ-001 Parameter WIDTH, default 4: operand and result width in bits.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset  input  1  synchronous active-high reset, sampled on posedge clk.
REQ-004 req0_valid / req1_valid  input  1  requester N has an operation pending.
REQ-005 req0_ready / req1_ready  output  1  handshake accept strobe for requester N.
REQ-006 req0_a, req0_b / req1_a, req1_b  input  WIDTH  operands from requester N.
REQ-007 req0_sub / req1_sub  input  1  operation select: 0 = A+B, 1 = A-B.
REQ-008 rsp_valid  output  1  result available.
REQ-009 rsp_ready  input  1  consumer accepts the result.
REQ-010 rsp_id  output  1  index of the requester that owns the result.
REQ-011 rsp_s  output  WIDTH  result, modulo 2^WIDTH.
REQ-012 rsp_cout  output  1  carry out; for subtraction 1 = no borrow (A>=B).
REQ-013 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-014 The FSM SHALL have three states, IDLE, EXEC and RESP, registered on posedge clk.
REQ-015 In IDLE with exactly one reqN_valid high, that requester SHALL be granted.
REQ-016 In IDLE with both requests valid, the requester other than last_grant SHALL be granted (round-robin).
REQ-017 reqN_ready SHALL be combinational: high only in IDLE and only for the granted requester; it SHALL never be high for both requesters.
REQ-018 On a handshake (valid && ready), operands, sub and the requester id SHALL be captured, last_grant SHALL be updated, and the FSM SHALL go to EXEC.
REQ-019 EXEC SHALL last exactly one cycle: it registers S = A + (B XOR {WIDTH{sub}}) + sub and the carry out of bit WIDTH-1, then moves to RESP.
REQ-020 In RESP, rsp_valid SHALL be high, and rsp_s, rsp_cout and rsp_id SHALL hold stable until rsp_ready is sampled high.
REQ-021 When rsp_valid && rsp_ready, the FSM SHALL return to IDLE; a new grant is possible in the following cycle.
REQ-022 Latency: a handshake at edge T SHALL produce rsp_valid high from edge T+2; throughput is at most one operation per 3 cycles.
REQ-023 Requests and operand changes outside IDLE SHALL be ignored and SHALL NOT affect the in-flight operation.
REQ-024 Arithmetic SHALL wrap modulo 2^WIDTH, and no overflow flag other than rsp_cout SHALL be produced.

Reset
REQ-025 When reset is high at a posedge, the following SHALL hold at that edge: state=IDLE, rsp_valid=0, rsp_s=0, rsp_cout=0, rsp_id=0, and last_grant=1, so req0 wins the first tie.
REQ-026 A reset in EXEC or RESP SHALL abandon the operation, and no response for it SHALL ever be issued.
REQ-027 reqN_ready SHALL be 0 during any cycle in which reset is high.

Configuration
REQ-028 Macro ALU_ARB_STATS_EN SHALL control the grant-statistics feature.
REQ-029 With ALU_ARB_STATS_EN defined, the block SHALL add output ports grant_cnt0 and grant_cnt1 (8 bits each), reset to 0, which increment on each handshake of their requester and saturate at 255.
REQ-030 Without ALU_ARB_STATS_EN, these ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-031 Shared package alu_arb_pkg SHALL hold the FSM state typedef (IDLE/EXEC/RESP), the OP_ADD=0 and OP_SUB=1 constants, and the default WIDTH constant.
REQ-032 Sub-module addsub_core SHALL contain the combinational WIDTH-bit add/sub: B XOR control, carry-in = control, outputs S and cout; it SHALL be instantiated once.

Verification
REQ-033 req0 a=3, b=5, sub=0 -> rsp_valid at T+2, rsp_s=8, rsp_cout=0, rsp_id=0.
REQ-034 req1 a=2, b=5, sub=1 -> rsp_s=13, rsp_cout=0, rsp_id=1; a=5, b=2, sub=1 -> rsp_s=3, rsp_cout=1.
REQ-035 req0 a=15, b=1, sub=0 -> rsp_s=0, rsp_cout=1.
REQ-036 Both valid continuously from reset with rsp_ready=1 -> rsp_id sequence 0,1,0,1, with one response every 3 cycles.
REQ-037 rsp_ready held low for 5 cycles in RESP -> outputs stable, both ready signals 0, busy=1; rsp_ready=1 -> IDLE on the next cycle.
REQ-038 reset asserted in EXEC -> next cycle rsp_valid=0, no response issued, and grant_cnt0=grant_cnt1=0 when ALU_ARB_STATS_EN is defined.
